regfile_hazard_unit: RTL and testbench

//  Register-file read side of the pipeline: 2^REG_SIZE x DATA_SIZE register array.
//  - Write port: fed by the write-back select.
//  - Read ports: two, combinational, feed the ALU operand selects.
//  - Interlock: a 3-deep in-flight destination tracker (EX/MEM/WB) raises stall on RAW hazards.
//  - Sits between decode and execute; no forwarding paths other than WB write-through.

---
 rtl/regfile_hazard_if.sv | 32 +++
 rtl/regfile_hazard_unit.sv | 71 +++++++
 tb/tb_regfile_hazard_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/regfile_hazard_if.sv
// regfile_hazard_if: decode/read-port/write-back bundle for regfile_hazard_unit.
interface regfile_hazard_if #(
    parameter int DATA_SIZE = 32,
    parameter int REG_SIZE  = 5,
    parameter int CODE_SIZE = 6
);
    logic                 id_valid;
    logic [CODE_SIZE-1:0] id_code;
    logic [REG_SIZE-1:0]  id_src_a;
    logic [REG_SIZE-1:0]  id_src_b;
    logic                 id_use_a;
    logic                 id_use_b;
    logic [REG_SIZE-1:0]  id_dst;
    logic [DATA_SIZE-1:0] ra_data;
    logic [DATA_SIZE-1:0] rb_data;
    logic                 stall;
    logic                 wb_en;
    logic [REG_SIZE-1:0]  wb_reg;
    logic [DATA_SIZE-1:0] wb_data;

    modport master (
        output id_valid, id_code, id_src_a, id_src_b, id_use_a, id_use_b, id_dst,
        output wb_en, wb_reg, wb_data,
        input  ra_data, rb_data, stall
    );

    modport slave (
        input  id_valid, id_code, id_src_a, id_src_b, id_use_a, id_use_b, id_dst,
        input  wb_en, wb_reg, wb_data,
        output ra_data, rb_data, stall
    );
endinterface

// File: rtl/regfile_hazard_unit.sv
// regfile_hazard_unit: register file with EX/MEM/WB RAW interlock.
// Define RF_WB_BYPASS_EN for write-through reads (interlock then covers EX/MEM only).
module regfile_hazard_unit #(
    parameter int DATA_SIZE = 32,
    parameter int REG_SIZE  = 5,
    parameter int CODE_SIZE = 6
) (
    input logic clk,
    input logic rst,
    regfile_hazard_if.slave bus
);
    localparam int NREG = 2 ** REG_SIZE;
    localparam logic [CODE_SIZE-1:0] ALU = CODE_SIZE'(1);
    localparam logic [CODE_SIZE-1:0] LW  = CODE_SIZE'(2);
`ifdef RF_WB_BYPASS_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 3;
`endif

    logic [DATA_SIZE-1:0] regs [NREG];
    // tracker index 0 = EX, 1 = MEM, 2 = WB
    logic [2:0]          v;
    logic [2:0]          wr;
    logic [REG_SIZE-1:0] dst [3];
    logic                hz_a, hz_b, id_wr, stall_c, byp_a, byp_b;

`ifdef RF_WB_BYPASS_EN
    assign byp_a = bus.wb_en && (bus.wb_reg == bus.id_src_a);
    assign byp_b = bus.wb_en && (bus.wb_reg == bus.id_src_b);
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    assign bus.ra_data = (bus.id_src_a == '0) ? '0 : byp_a ? bus.wb_data : regs[bus.id_src_a];
    assign bus.rb_data = (bus.id_src_b == '0) ? '0 : byp_b ? bus.wb_data : regs[bus.id_src_b];

    always_comb begin
        hz_a = 1'b0;
        hz_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hz_a = hz_a | (v[i] & wr[i] & (dst[i] == bus.id_src_a));
            hz_b = hz_b | (v[i] & wr[i] & (dst[i] == bus.id_src_b));
        end
        hz_a = hz_a & bus.id_use_a & (bus.id_src_a != '0);
        hz_b = hz_b & bus.id_use_b & (bus.id_src_b != '0);
    end

    assign id_wr     = ((bus.id_code == ALU) || (bus.id_code == LW)) && (bus.id_dst != '0);
    assign stall_c   = !rst && bus.id_valid && (hz_a || hz_b);
    assign bus.stall = stall_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            v      <= '0;
            wr     <= '0;
            dst[0] <= '0;
            dst[1] <= '0;
            dst[2] <= '0;
        end else begin
            if (bus.wb_en && (bus.wb_reg != '0)) regs[bus.wb_reg] <= bus.wb_data;
            v      <= {v[1:0], bus.id_valid && !stall_c};
            wr     <= {wr[1:0], id_wr};
            dst[0] <= bus.id_dst;
            dst[1] <= dst[0];
            dst[2] <= dst[1];
        end
    end
endmodule

// File: tb/tb_regfile_hazard_unit.sv
// tb_regfile_hazard_unit: directed vectors with a queued-expectation scoreboard.
module tb_regfile_hazard_unit;
`ifdef RF_WB_BYPASS_EN
    localparam int STALLS = 2;
`else
    localparam int STALLS = 3;
`endif
    localparam logic [5:0] ALU = 6'd1, LW = 6'd2, SW = 6'd3;

    typedef struct {
        string       name;
        bit          ca;
        logic [31:0] ra;
        bit          cb;
        logic [31:0] rb;
        logic        st;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_hazard_if #(.DATA_SIZE(32), .REG_SIZE(5), .CODE_SIZE(6)) bus ();
    regfile_hazard_unit #(.DATA_SIZE(32), .REG_SIZE(5), .CODE_SIZE(6)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (bus.stall !== e.st) begin
                n_fail++;
                $display("FAIL %s stall: got %b want %b", e.name, bus.stall, e.st);
            end
            if (e.ca) begin
                n_checks++;
                if (bus.ra_data !== e.ra) begin
                    n_fail++;
                    $display("FAIL %s ra_data: got %h want %h", e.name, bus.ra_data, e.ra);
                end
            end
            if (e.cb) begin
                n_checks++;
                if (bus.rb_data !== e.rb) begin
                    n_fail++;
                    $display("FAIL %s rb_data: got %h want %h", e.name, bus.rb_data, e.rb);
                end
            end
        end
    end

    task automatic cyc(input string nm, input bit ca, input logic [31:0] ea,
                       input bit cb, input logic [31:0] eb, input logic es);
        q.push_back('{nm, ca, ea, cb, eb, es});
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] code, input logic [4:0] sa, input logic ua,
                         input logic [4:0] sb, input logic ub, input logic [4:0] d);
        bus.id_valid = 1'b1;
        bus.id_code  = code;
        bus.id_src_a = sa;
        bus.id_use_a = ua;
        bus.id_src_b = sb;
        bus.id_use_b = ub;
        bus.id_dst   = d;
    endtask

    initial begin
        rst = 1'b1;
        bus.id_valid = 1'b0;
        bus.id_code = '0;
        bus.id_src_a = '0;
        bus.id_src_b = '0;
        bus.id_use_a = 1'b0;
        bus.id_use_b = 1'b0;
        bus.id_dst = '0;
        bus.wb_en = 1'b0;
        bus.wb_reg = '0;
        bus.wb_data = '0;
        @(posedge clk);
        #1;
        cyc("reset", 0, 0, 0, 0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            issue(ALU, 5'(i), 1'b1, 5'(31 - i), 1'b1, 5'd0);
            cyc($sformatf("rst_read%0d", i), 1, 32'h0, 1, 32'h0, 1'b0);
        end
        // write/read of r5, and a dropped write to r0
        bus.id_valid = 1'b0;
        bus.id_src_a = 5'd0;
        bus.id_src_b = 5'd0;
        bus.wb_en = 1'b1;
        bus.wb_reg = 5'd5;
        bus.wb_data = 32'hDEADBEEF;
        cyc("wr_r5", 1, 32'h0, 0, 0, 1'b0);
        bus.wb_reg = 5'd0;
        bus.wb_data = 32'hFFFFFFFF;
        bus.id_src_a = 5'd5;
        bus.id_src_b = 5'd5;
        cyc("rd_r5", 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1'b0);
        bus.wb_en = 1'b0;
        bus.id_src_a = 5'd0;
        cyc("rd_r0", 1, 32'h0, 0, 0, 1'b0);
        // LW -> dependent ALU interlock
        issue(LW, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8);
        cyc("lw_r8", 0, 0, 0, 0, 1'b0);
        issue(ALU, 5'd8, 1'b1, 5'd0, 1'b0, 5'd10);
        for (int k = 1; k <= STALLS; k++) begin
            bus.wb_en = (k == 3);
            bus.wb_reg = 5'd8;
            bus.wb_data = 32'h1234;
            cyc($sformatf("raw_stall%0d", k), 0, 0, 0, 0, 1'b1);
        end
        bus.wb_en = (STALLS == 2);
        cyc("raw_release", 1, 32'h1234, 0, 0, 1'b0);
        bus.wb_en = 1'b0;
        bus.id_valid = 1'b0;
        for (int k = 0; k < 3; k++) cyc("drain1", 0, 0, 0, 0, 1'b0);
        // non-writing producers and unused sources
        issue(SW, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8);
        cyc("sw_r8", 0, 0, 0, 0, 1'b0);
        issue(ALU, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0);
        cyc("after_sw", 1, 32'h1234, 0, 0, 1'b0);
        issue(LW, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8);
        cyc("lw_r8b", 0, 0, 0, 0, 1'b0);
        issue(ALU, 5'd8, 1'b0, 5'd8, 1'b0, 5'd0);
        cyc("unused_src", 1, 32'h1234, 0, 0, 1'b0);
        issue(ALU, 5'd0, 1'b0, 5'd8, 1'b1, 5'd0);
        cyc("src_b_mem_hz", 0, 0, 0, 0, 1'b1);
        bus.id_valid = 1'b0;
        for (int k = 0; k < 3; k++) cyc("drain2", 0, 0, 0, 0, 1'b0);
        // independent back-to-back issues and r0 sources
        issue(ALU, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3);
        cyc("indep1", 0, 0, 0, 0, 1'b0);
        issue(ALU, 5'd4, 1'b1, 5'd6, 1'b1, 5'd7);
        cyc("indep2", 0, 0, 0, 0, 1'b0);
        issue(ALU, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        cyc("r0_src", 1, 32'h0, 1, 32'h0, 1'b0);
        issue(ALU, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        cyc("r0_src2", 0, 0, 0, 0, 1'b0);
        bus.id_valid = 1'b0;
        for (int k = 0; k < 3; k++) cyc("drain3", 0, 0, 0, 0, 1'b0);
        // reset while stalled
        issue(LW, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9);
        cyc("lw_r9", 0, 0, 0, 0, 1'b0);
        issue(ALU, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0);
        cyc("r9_stall", 0, 0, 0, 0, 1'b1);
        rst = 1'b1;
        bus.wb_en = 1'b1;
        bus.wb_reg = 5'd5;
        bus.wb_data = 32'h55555555;
        cyc("rst_stall", 0, 0, 0, 0, 1'b0);
        rst = 1'b0;
        bus.wb_en = 1'b0;
        issue(ALU, 5'd9, 1'b1, 5'd5, 1'b1, 5'd0);
        cyc("post_rst", 1, 32'h0, 1, 32'h0, 1'b0);
        issue(ALU, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0);
        cyc("post_rst_r8", 1, 32'h0, 0, 0, 1'b0);
        bus.id_valid = 1'b0;
        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
